// File: rtl/sram_addr_gen.sv
// SRAM address source for the CPLD bus path: deserialises an AVR-shifted address
// and commits it to a counter. Define SRAM_ADDR_AUTOINC_EN for post-increment on each access.
module sram_addr_gen #(
  parameter int ADDR_WIDTH  = 21,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  avr_clk,
  input  logic                  avr_reset,
  input  logic                  avr_si,
  input  logic                  avr_sreg_clk,
  input  logic                  avr_oe,
  input  logic                  avr_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  addr_valid,
  output logic                  shift_busy
);

  localparam int BCNT_W = $clog2(ADDR_WIDTH + 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(ADDR_WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  logic [SYNC_STAGES-1:0] si_sync_q, si_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic                   sck_hist_q, sck_hist_d;
  logic                   sh_rise;
  logic                   si_bit;
  logic                   acc_end;

  logic [1:0]            state_q, state_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [ADDR_WIDTH-1:0] shreg_q, shreg_d;
  logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic                  addr_valid_q, addr_valid_d;

  // Data and shift clock share the same depth so the sampled bit lines up with its edge.
  always_comb begin
    si_sync_d  = {si_sync_q[SYNC_STAGES-2:0], avr_si};
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], avr_sreg_clk};
    sck_hist_d = sck_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) begin
      si_sync_q  <= '0;
      sck_sync_q <= '0;
      sck_hist_q <= 1'b0;
    end else begin
      si_sync_q  <= si_sync_d;
      sck_sync_q <= sck_sync_d;
      sck_hist_q <= sck_hist_d;
    end
  end

  assign sh_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_hist_q;
  assign si_bit  = si_sync_q[SYNC_STAGES-1];

`ifdef SRAM_ADDR_AUTOINC_EN
  logic [SYNC_STAGES-1:0] oe_sync_q, oe_sync_d;
  logic [SYNC_STAGES-1:0] we_sync_q, we_sync_d;
  logic                   oe_hist_q, oe_hist_d;
  logic                   we_hist_q, we_hist_d;

  always_comb begin
    oe_sync_d = {oe_sync_q[SYNC_STAGES-2:0], avr_oe};
    we_sync_d = {we_sync_q[SYNC_STAGES-2:0], avr_we};
    oe_hist_d = oe_sync_q[SYNC_STAGES-1];
    we_hist_d = we_sync_q[SYNC_STAGES-1];
  end

  // Strobes idle high, so reset to 1 to avoid a phantom end-of-access.
  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) begin
      oe_sync_q <= '1;
      we_sync_q <= '1;
      oe_hist_q <= 1'b1;
      we_hist_q <= 1'b1;
    end else begin
      oe_sync_q <= oe_sync_d;
      we_sync_q <= we_sync_d;
      oe_hist_q <= oe_hist_d;
      we_hist_q <= we_hist_d;
    end
  end

  assign acc_end = (oe_sync_q[SYNC_STAGES-1] & ~oe_hist_q) |
                   (we_sync_q[SYNC_STAGES-1] & ~we_hist_q);
`else
  logic unused_strobes;
  assign unused_strobes = avr_oe ^ avr_we;
  assign acc_end        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    shreg_d      = shreg_q;
    sram_addr_d  = sram_addr_q;
    addr_valid_d = addr_valid_q;
    if (state_q == ST_LOAD) begin
      // Commit beats a coincident increment; a new bit restarts an emptied frame.
      sram_addr_d  = shreg_q;
      addr_valid_d = 1'b1;
      if (sh_rise) begin
        shreg_d = {{(ADDR_WIDTH-1){1'b0}}, si_bit};
        bcnt_d  = BCNT_W'(1);
        state_d = ST_SHIFT;
      end else begin
        bcnt_d  = '0;
        state_d = ST_IDLE;
      end
    end else begin
      if (acc_end) begin
        sram_addr_d = sram_addr_q + ADDR_WIDTH'(1);
      end
      if (sh_rise) begin
        shreg_d = {shreg_q[ADDR_WIDTH-2:0], si_bit};
        bcnt_d  = bcnt_q + BCNT_W'(1);
        state_d = (bcnt_q == BCNT_LAST) ? ST_LOAD : ST_SHIFT;
      end
    end
  end

  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) begin
      state_q      <= ST_IDLE;
      bcnt_q       <= '0;
      shreg_q      <= '0;
      sram_addr_q  <= '0;
      addr_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      shreg_q      <= shreg_d;
      sram_addr_q  <= sram_addr_d;
      addr_valid_q <= addr_valid_d;
    end
  end

  assign sram_addr  = sram_addr_q;
  assign addr_valid = addr_valid_q;
  assign shift_busy = (bcnt_q != '0) && (state_q != ST_LOAD);

endmodule

// File: tb/tb_sram_addr_gen.sv
// Scoreboard bench for sram_addr_gen; expected addresses are queued as stimulus is driven.
module tb_sram_addr_gen;

`ifdef SRAM_ADDR_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        avr_clk = 1'b0;
  logic        avr_reset;
  logic        avr_si;
  logic        avr_sreg_clk;
  logic        avr_oe;
  logic        avr_we;
  logic [20:0] sram_addr;
  logic        addr_valid;
  logic        shift_busy;

  logic [20:0] exp_q[$];
  logic [20:0] exp_v;
  logic [20:0] model_addr;
  int          n_checks = 0;
  int          n_fail   = 0;

  sram_addr_gen #(.ADDR_WIDTH(21), .SYNC_STAGES(2)) dut (
    .avr_clk      (avr_clk),
    .avr_reset    (avr_reset),
    .avr_si       (avr_si),
    .avr_sreg_clk (avr_sreg_clk),
    .avr_oe       (avr_oe),
    .avr_we       (avr_we),
    .sram_addr    (sram_addr),
    .addr_valid   (addr_valid),
    .shift_busy   (shift_busy)
  );

  always #5 avr_clk = ~avr_clk;

  function automatic logic [20:0] inc_model(input logic [20:0] a);
    return AUTOINC ? a + 21'd1 : a;
  endfunction

  task automatic tick();
    @(posedge avr_clk);
    #1;
  endtask

  // MSB first; returns right after the final rising shift clock is driven.
  task automatic send_bits(input logic [20:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      avr_si       = val[i];
      avr_sreg_clk = 1'b0;
      repeat (4) tick();
      avr_sreg_clk = 1'b1;
      if (i != 0) repeat (4) tick();
    end
  endtask

  task automatic load_addr(input logic [20:0] val);
    send_bits(val, 21);
    repeat (4) tick();
    avr_sreg_clk = 1'b0;
  endtask

  // Returns one cycle before the end-of-access edge is acted on.
  task automatic strobe_pulse(input bit use_oe, input bit use_we);
    avr_oe = use_oe ? 1'b0 : 1'b1;
    avr_we = use_we ? 1'b0 : 1'b1;
    repeat (4) tick();
    avr_oe = 1'b1;
    avr_we = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset();
    avr_reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (sram_addr !== 21'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected %h", sram_addr, 21'h0); end
    n_checks++;
    if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", addr_valid); end
    n_checks++;
    if (shift_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", shift_busy); end
    avr_reset = 1'b0;
    repeat (2) tick();

    send_bits(21'h3A5, 10);
    repeat (4) tick();
    n_checks++;
    if (shift_busy !== 1'b1) begin n_fail++; $display("FAIL midframe_busy: got %b expected 1", shift_busy); end
    avr_reset    = 1'b1;
    avr_sreg_clk = 1'b0;
    #1;
    n_checks++;
    if (sram_addr !== 21'h0) begin n_fail++; $display("FAIL midrst_addr: got %h expected %h", sram_addr, 21'h0); end
    n_checks++;
    if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", addr_valid); end
    n_checks++;
    if (shift_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", shift_busy); end
    repeat (2) tick();
    avr_reset = 1'b0;
    repeat (4) tick();

    exp_q.push_back(21'h0A5A5A);
    send_bits(21'h0A5A5A, 21);
    repeat (3) tick();
    n_checks++;
    if (sram_addr !== 21'h0) begin n_fail++; $display("FAIL early_commit: got %h expected %h", sram_addr, 21'h0); end
    n_checks++;
    if (addr_valid !== 1'b0) begin n_fail++; $display("FAIL early_valid: got %b expected 0", addr_valid); end
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL frame_commit: got %h expected %h", sram_addr, exp_v); end
    n_checks++;
    if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL frame_valid: got %b expected 1", addr_valid); end
    n_checks++;
    if (shift_busy !== 1'b0) begin n_fail++; $display("FAIL frame_busy: got %b expected 0", shift_busy); end
    repeat (3) tick();
    avr_sreg_clk = 1'b0;
    model_addr = exp_v;
  endtask

  task automatic test_autoinc();
    exp_q.push_back(21'h000010);
    load_addr(21'h000010);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL inc_load: got %h expected %h", sram_addr, exp_v); end
    model_addr = exp_v;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(inc_model(model_addr));
      strobe_pulse(1'b1, 1'b0);
      n_checks++;
      if (sram_addr !== model_addr) begin n_fail++; $display("FAIL inc_early%0d: got %h expected %h", i, sram_addr, model_addr); end
      tick();
      exp_v = exp_q.pop_front();
      n_checks++;
      if (sram_addr !== exp_v) begin n_fail++; $display("FAIL inc_step%0d: got %h expected %h", i, sram_addr, exp_v); end
      model_addr = exp_v;
    end
  endtask

  task automatic test_wrap();
    exp_q.push_back(21'h1FFFFF);
    load_addr(21'h1FFFFF);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL wrap_load: got %h expected %h", sram_addr, exp_v); end
    model_addr = exp_v;
    exp_q.push_back(inc_model(model_addr));
    strobe_pulse(1'b0, 1'b1);
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL wrap_addr: got %h expected %h", sram_addr, exp_v); end
    n_checks++;
    if (addr_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %b expected 1", addr_valid); end
    model_addr = exp_v;
  endtask

  task automatic test_partial_frame();
    exp_q.push_back(21'h000100);
    load_addr(21'h000100);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL part_load: got %h expected %h", sram_addr, exp_v); end
    model_addr = exp_v;
    send_bits(21'h155555 >> 13, 8);
    repeat (4) tick();
    avr_sreg_clk = 1'b0;
    n_checks++;
    if (shift_busy !== 1'b1) begin n_fail++; $display("FAIL part_busy: got %b expected 1", shift_busy); end
    exp_q.push_back(inc_model(model_addr));
    strobe_pulse(1'b1, 1'b0);
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL part_inc: got %h expected %h", sram_addr, exp_v); end
    n_checks++;
    if (shift_busy !== 1'b1) begin n_fail++; $display("FAIL part_busy_after: got %b expected 1", shift_busy); end
    model_addr = exp_v;
    exp_q.push_back(21'h155555);
    send_bits(21'h155555 & 21'h001FFF, 13);
    repeat (4) tick();
    avr_sreg_clk = 1'b0;
    exp_v = exp_q.pop_front();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL part_commit: got %h expected %h", sram_addr, exp_v); end
    model_addr = exp_v;
  endtask

  task automatic test_load_collision();
    avr_oe = 1'b0;
    exp_q.push_back(21'h000200);
    send_bits(21'h000200, 21);
    tick();
    avr_oe = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (sram_addr !== model_addr) begin n_fail++; $display("FAIL coll_early: got %h expected %h", sram_addr, model_addr); end
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL coll_commit: got %h expected %h", sram_addr, exp_v); end
    repeat (4) tick();
    avr_sreg_clk = 1'b0;
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL coll_hold: got %h expected %h", sram_addr, exp_v); end
    model_addr = exp_v;
  endtask

  task automatic test_dual_strobe();
    exp_q.push_back(21'h000300);
    load_addr(21'h000300);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL dual_load: got %h expected %h", sram_addr, exp_v); end
    model_addr = exp_v;
    exp_q.push_back(inc_model(model_addr));
    strobe_pulse(1'b1, 1'b1);
    tick();
    exp_v = exp_q.pop_front();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL dual_inc: got %h expected %h", sram_addr, exp_v); end
    repeat (4) tick();
    n_checks++;
    if (sram_addr !== exp_v) begin n_fail++; $display("FAIL dual_single: got %h expected %h", sram_addr, exp_v); end
    model_addr = exp_v;
  endtask

  initial begin
    avr_reset    = 1'b1;
    avr_si       = 1'b0;
    avr_sreg_clk = 1'b0;
    avr_oe       = 1'b1;
    avr_we       = 1'b1;
    model_addr   = '0;
    test_reset();
    test_autoinc();
    test_wrap();
    test_partial_frame();
    test_load_collision();
    test_dual_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
